dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data-cache controller for the MEM stage of the pipelined MIPS core. It holds the tag/valid arrays and sequences line refills and write-throughs to main memory over a word-wide request/ready handshake. It drives the external data array's write port and produces `hit`, which gates the MEM/WB pipeline register: the pipeline advances only while `hit` is 1.

## Interface
Parameters:
- `INDEX_BITS`, 6: number of line-index bits (2^INDEX_BITS lines); 4 words per line, fixed.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_read`  in  1  MEM-stage load request.
- `cpu_write`  in  1  MEM-stage store request; wins over `cpu_read` if both are set.
- `cpu_addr`  in  32  byte address; tag = [31:INDEX_BITS+4], index = [INDEX_BITS+3:4], word = [3:2], [1:0] ignored.
- `cpu_wdata`  in  32  store data.
- `hit`  out  1  1 = access satisfied or no access; pipeline may advance.
- `mem_req`  out  1  memory request, held until accepted.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  write data.
- `mem_ready`  in  1  beat accepted/completed this cycle when `mem_req` = 1.
- `mem_rdata`  in  32  read data, valid with `mem_ready`.
- `arr_we`  out  1  data-array write enable.
- `arr_index`  out  INDEX_BITS  data-array line.
- `arr_word`  out  2  data-array word.
- `arr_wdata`  out  32  data-array write data.
- `miss_count`  out  16  read-miss counter, saturating.

## Operation
- States: IDLE, REFILL, WRITE, DONE. Tag/valid arrays are flops.
- Lookup: match = `valid[index]` and `tag_mem[index] == tag`.
- IDLE:
  - No request: `hit` = 1.
  - Read with match: `hit` = 1 (combinational), stay in IDLE.
  - Read miss: `hit` = 0. Latch the address, clear word counter `cnt`, increment `miss_count`, go to REFILL.
  - Write: `hit` = 0. Latch address and data, go to WRITE.
- REFILL:
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = {latched tag, index, `cnt`, 2'b00}, `hit` = 0.
  - Each cycle with `mem_ready`: `arr_we` = 1, `arr_wdata` = `mem_rdata`, `arr_word` = `cnt`, then `cnt`++.
  - On the beat with `cnt` == 3: set valid, write the tag, go to DONE.
- WRITE:
  - `mem_req` = 1, `mem_we` = 1, `mem_addr` = latched word address, `mem_wdata` = latched data, `hit` = 0.
  - On `mem_ready`: if the latched address matches (checked at that cycle), also `arr_we` = 1 with the latched data and word. Go to DONE.
  - On a miss, no allocation.
- DONE: `hit` = 1 for exactly one cycle, requests ignored, then IDLE. This stops a still-asserted request from re-triggering.
- `arr_index` and `arr_word` are driven from the latched address in REFILL, WRITE and DONE; they are don't-care in IDLE when `arr_we` = 0.
- `arr_we` = 0 in all other cases.
- `miss_count`: +1 on each IDLE→REFILL transition; holds at 0xFFFF. Writes are not counted.

## Timing
- Reset (while `rst` = 1 and in the cycle after): state = IDLE, all valid bits = 0, `miss_count` = 0, `cnt` = 0.
- Outputs under reset: `mem_req` = 0, `mem_we` = 0, `arr_we` = 0, `hit` = 0. `mem_addr`/`mem_wdata` = 0.
- Reset mid-REFILL or mid-WRITE abandons the transaction: `mem_req` is 0 on the next cycle and the partially filled line stays invalid.
- Read hit: zero stall cycles.
- Read miss: 1 IDLE cycle plus at least 4 REFILL cycles with `hit` = 0, one per `mem_ready`. Then DONE with `hit` = 1. Minimum 5 stall cycles.
- Write: 1 IDLE cycle plus at least 1 WRITE cycle with `hit` = 0, then DONE. Minimum 2 stall cycles.
- `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are Moore outputs of state and latched registers. They must stay stable while `mem_req` = 1 and `mem_ready` = 0, including arbitrary wait states.
- A `mem_ready` while `mem_req` = 0 is ignored.
- `cpu_*` inputs may change during a stall; only the latched copies are used.

## Test plan
- Reset then read 0x0000_0040: `hit` = 0. Four `mem_req` reads at 0x40, 0x44, 0x48, 0x4C with `arr_we` pulses for words 0..3. DONE `hit` = 1 for one cycle; `miss_count` = 1. A second read of 0x0000_0044 gives `hit` = 1 immediately.
- Refill with `mem_ready` low for 3 cycles before beat 2: `mem_addr` is held at 0x48, no extra `arr_we`, and `hit` stays 0 throughout.
- Store 0xDEADBEEF to cached 0x0000_0048: one write with `mem_we` = 1 at 0x48. `arr_we` = 1 with word 2 on the ready cycle, then DONE. Store to uncached 0x0000_1000: memory write only, `arr_we` stays 0.
- Conflict: read 0x0000_0040, then read 0x0000_0440 (same index, different tag): second access misses and refills. A re-read of 0x40 misses again; `miss_count` = 3.
- Assert `rst` after refill beat 2: next cycle `mem_req` = 0 and state = IDLE. A read of the same address misses and `miss_count` = 1.
- Force `miss_count` to 0xFFFF via 65535 misses (or a backdoor preload): the next miss leaves it at 0xFFFF.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller for the MEM stage.
// Holds tag/valid state and sequences line refills and store write-throughs over a word handshake.
module dcache_ctrl #(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic                  arr_we,
    output logic [INDEX_BITS-1:0] arr_index,
    output logic [1:0]            arr_word,
    output logic [31:0]           arr_wdata,
    output logic [15:0]           miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag [LINES];
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_cnt;
    logic [15:0]           r_miss_count;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_l_tag;
    logic [INDEX_BITS-1:0] w_l_idx;
    logic                  w_match;
    logic                  w_l_match;
    logic                  w_start_miss;
    logic                  w_start_write;
    logic                  w_beat;
    logic                  w_fill_done;
    logic                  w_unused;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_tag     = cpu_addr[31:INDEX_BITS+4];
    assign w_idx     = cpu_addr[INDEX_BITS+3:4];
    assign w_l_tag   = r_addr[31:INDEX_BITS+4];
    assign w_l_idx   = r_addr[INDEX_BITS+3:4];
    assign w_match   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_l_match = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);
    assign w_beat      = (r_state == S_REFILL) && mem_ready;
    assign w_fill_done = w_beat && (r_cnt == 2'd3);
    assign miss_count  = r_miss_count;
    assign w_unused    = ^cpu_addr[1:0];

    always_comb begin
        w_next        = r_state;
        w_start_miss  = 1'b0;
        w_start_write = 1'b0;
        hit           = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        arr_we        = 1'b0;
        arr_index     = w_l_idx;
        arr_word      = r_addr[3:2];
        arr_wdata     = r_wdata;
        case (r_state)
            S_IDLE: begin
                arr_index = w_idx;
                arr_word  = cpu_addr[3:2];
                if (cpu_write) begin
                    w_start_write = 1'b1;
                    w_next        = S_WRITE;
                end else if (cpu_read && !w_match) begin
                    w_start_miss = 1'b1;
                    w_next       = S_REFILL;
                end else begin
                    hit = 1'b1;
                end
            end
            S_REFILL: begin
                mem_req   = 1'b1;
                mem_addr  = {r_addr[31:4], r_cnt, 2'b00};
                arr_word  = r_cnt;
                arr_wdata = mem_rdata;
                if (mem_ready) begin
                    arr_we = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (mem_ready) begin
                    // Update the array only if the line is resident; misses are not allocated.
                    arr_we = w_l_match;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                hit    = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset kills any in-flight transaction immediately, including the handshake outputs.
        if (rst) begin
            w_next    = S_IDLE;
            hit       = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = 32'd0;
            mem_wdata = 32'd0;
            arr_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_cnt        <= 2'd0;
            r_miss_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_start_miss) begin
                r_cnt        <= 2'd0;
                r_miss_count <= sat_inc(r_miss_count);
            end else if (w_beat) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_fill_done) begin
                r_valid[w_l_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_miss || w_start_write) begin
            r_addr <= {cpu_addr[31:2], 2'b00};
        end
        if (w_start_write) begin
            r_wdata <= cpu_wdata;
        end
        if (w_fill_done) begin
            r_tag[w_l_idx] <= w_l_tag;
        end
    end

endmodule
